// File: rtl/aes_frame_loader.sv
// Byte-stream loader for the AES core: collects header, plaintext and key into
// shadow registers, publishes them atomically on the last key byte, then launches.
module aes_frame_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic         clr,
    input  logic         core_done,
    output logic [127:0] in_block,
    output logic [255:0] key,
    output logic [1:0]   mode,
    output logic         start,
    output logic         frame_err
);

    typedef enum logic [2:0] {IDLE, PT, KEY, LAUNCH, WAIT} state_t;

    localparam logic [127:0] PT_RST  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_RST =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    state_t         state;
    logic [4:0]     cnt;
    logic [1:0]     sh_mode;
    logic [127:0]   sh_pt;
    logic [255:0]   sh_key;
    logic [4:0]     key_last;
    logic           accept;
    logic [127:0]   pt_merged;
    logic [255:0]   key_merged;

    assign accept = byte_valid & byte_ready;

    // Shadows are zeroed at the start of their field, so OR-ing the shifted byte
    // into place is enough to build the MSB-first image.
    assign pt_merged  = sh_pt  | ({byte_in, 120'b0} >> {cnt[3:0], 3'b000});
    assign key_merged = sh_key | ({byte_in, 248'b0} >> {cnt, 3'b000});

    always_comb begin
        key_last = 5'd31;
        case (sh_mode)
            2'd0:    key_last = 5'd15;
            2'd1:    key_last = 5'd23;
            default: key_last = 5'd31;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sh_mode    <= '0;
            sh_pt      <= '0;
            sh_key     <= '0;
            in_block   <= PT_RST;
            key        <= KEY_RST;
            mode       <= 2'd2;
            byte_ready <= 1'b1;
            start      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            start     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (accept) begin
                        if (byte_in[1:0] == 2'd3) begin
                            frame_err <= 1'b1;
                        end else begin
                            sh_mode <= byte_in[1:0];
                            sh_pt   <= '0;
                            cnt     <= '0;
                            state   <= PT;
                        end
                    end
                end
                PT: begin
                    if (clr) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (accept) begin
                        sh_pt <= pt_merged;
                        if (cnt == 5'd15) begin
                            cnt    <= '0;
                            sh_key <= '0;
                            state  <= KEY;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                KEY: begin
                    if (clr) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (accept) begin
                        sh_key <= key_merged;
                        if (cnt == key_last) begin
                            // Publish including the byte accepted on this edge.
                            in_block   <= sh_pt;
                            key        <= key_merged;
                            mode       <= sh_mode;
                            start      <= 1'b1;
                            byte_ready <= 1'b0;
                            cnt        <= '0;
                            state      <= LAUNCH;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (core_done) begin
                        byte_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    byte_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_frame_loader.sv
// Directed-plus-random bench for aes_frame_loader; expectations come from
// assembling each frame's bytes directly in the bench.
module tb_aes_frame_loader;

    localparam logic [127:0] PT_RST  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_RST =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   byte_in = '0;
    logic         byte_valid = 1'b0;
    logic         byte_ready;
    logic         clr = 1'b0;
    logic         core_done = 1'b0;
    logic [127:0] in_block;
    logic [255:0] key;
    logic [1:0]   mode;
    logic         start;
    logic         frame_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    logic [127:0] pub_pt   = PT_RST;
    logic [255:0] pub_key  = KEY_RST;
    logic [1:0]   pub_mode = 2'd2;

    aes_frame_loader dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .clr(clr), .core_done(core_done),
        .in_block(in_block), .key(key), .mode(mode), .start(start),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (start) start_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_published(input string tag);
        chk({tag, "_in_block"}, in_block, pub_pt);
        chk({tag, "_key"}, key, pub_key);
        chk({tag, "_mode"}, mode, pub_mode);
    endtask

    // Present one byte and hold it until the next edge where byte_ready is high.
    task automatic send(input logic [7:0] b, input bit gap, output int waited);
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (!byte_ready && waited < 60) begin
            step();
            waited++;
        end
        if (!byte_ready) begin
            chk("send_timeout", byte_ready, 1'b1);
            byte_valid = 1'b0;
            return;
        end
        step();
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        if (gap) step();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction

    // gapmode: 0 none, 1 valid toggles every cycle, 2 random gaps.
    // hold=1 leaves the FSM in LAUNCH after the last byte without handling WAIT.
    task automatic send_frame(input logic [1:0] m, input logic [5:0] hdr_hi,
                              input logic [127:0] pt, input logic [255:0] kfull,
                              input int gapmode, input bit hold, output int hdr_wait);
        int kbytes;
        int w;
        bit g;
        logic [255:0] exp_key;
        kbytes  = 16 + 8 * int'(m);
        exp_key = '0;
        for (int i = 0; i < kbytes; i++) exp_key[255 - 8*i -: 8] = kfull[255 - 8*i -: 8];
        g = (gapmode == 1) || (gapmode == 2 && $urandom_range(0, 1) == 1);
        send({hdr_hi, m}, g, hdr_wait);
        for (int i = 0; i < 16; i++) begin
            g = (gapmode == 1) || (gapmode == 2 && $urandom_range(0, 1) == 1);
            send(pt[127 - 8*i -: 8], g, w);
        end
        for (int i = 0; i < kbytes; i++) begin
            g = (i != kbytes - 1) &&
                ((gapmode == 1) || (gapmode == 2 && $urandom_range(0, 1) == 1));
            send(kfull[255 - 8*i -: 8], g, w);
        end
        pub_pt   = pt;
        pub_key  = exp_key;
        pub_mode = m;
        chk_published("frame");
        chk("frame_start", start, 1'b1);
        chk("frame_ready_launch", byte_ready, 1'b0);
        if (!hold) begin
            byte_valid = 1'b1;
            step();
            chk("wait_start_low", start, 1'b0);
            chk("wait_refuse0", byte_ready, 1'b0);
            step();
            chk("wait_refuse1", byte_ready, 1'b0);
            byte_valid = 1'b0;
            core_done  = 1'b1;
            step();
            core_done = 1'b0;
            chk("idle_ready", byte_ready, 1'b1);
            chk_published("held");
        end
    endtask

    initial begin
        int w;
        int hw;
        int s0;
        logic [1:0] m;

        // Reset state
        repeat (3) step();
        chk_published("rst");
        chk("rst_ready", byte_ready, 1'b1);
        chk("rst_start", start, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        rst = 1'b1;
        step();

        // Reset mid-frame
        send(8'h02, 0, w);
        for (int i = 0; i < 5; i++) send(8'($urandom), 0, w);
        rst = 1'b0;
        #1;
        chk_published("rst_mid");
        chk("rst_mid_ready", byte_ready, 1'b1);
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_start", start, 1'b0);

        // FIPS-197 mode 0 frame
        s0 = start_cnt;
        send_frame(2'd0, 6'd0, 128'h00112233445566778899aabbccddeeff,
                   {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0, 0, hw);
        chk("fips_one_start", start_cnt - s0, 1);

        // Mode 1 with byte_valid toggling
        send_frame(2'd1, 6'd0, rand128(), rand256(), 1, 0, hw);

        // Illegal header: upper bits ignored, low bits = 3
        send(8'hff, 0, w);
        chk("err_pulse", frame_err, 1'b1);
        chk("err_ready", byte_ready, 1'b1);
        step();
        chk("err_single", frame_err, 1'b0);
        chk_published("err_hold");
        send_frame(2'd2, 6'h3f, rand128(), rand256(), 0, 0, hw);
        chk("after_err_hdr_wait", hw, 0);

        // Abort in KEY after 10 key bytes, clr with a simultaneous valid byte
        s0 = start_cnt;
        send(8'h02, 0, w);
        for (int i = 0; i < 26; i++) send(8'($urandom), 0, w);
        byte_in    = 8'h5a;
        byte_valid = 1'b1;
        clr        = 1'b1;
        step();
        clr        = 1'b0;
        byte_valid = 1'b0;
        chk("abort_ready", byte_ready, 1'b1);
        chk("abort_start", start, 1'b0);
        chk_published("abort");
        send_frame(2'd0, 6'd0, rand128(), rand256(), 0, 0, hw);
        chk("abort_next_hdr", hw, 0);
        chk("abort_starts", start_cnt - s0, 1);

        // Reset during WAIT restores defaults without a start
        send_frame(2'd1, 6'd0, rand128(), rand256(), 0, 1, hw);
        step();
        s0  = start_cnt;
        rst = 1'b0;
        #1;
        pub_pt = PT_RST; pub_key = KEY_RST; pub_mode = 2'd2;
        chk_published("rst_wait");
        chk("rst_wait_ready", byte_ready, 1'b1);
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("rst_wait_nostart", start_cnt - s0, 0);

        // Back-to-back with core_done held high
        core_done = 1'b1;
        s0 = start_cnt;
        send_frame(2'($urandom_range(0, 2)), 6'($urandom), rand128(), rand256(), 0, 1, hw);
        send_frame(2'($urandom_range(0, 2)), 6'($urandom), rand128(), rand256(), 0, 1, hw);
        chk("b2b_hdr_wait", hw, 2);
        step();
        step();
        core_done = 1'b0;
        chk("b2b_two_starts", start_cnt - s0, 2);
        chk("b2b_idle", byte_ready, 1'b1);

        // Random frames with random gaps
        for (int f = 0; f < 6; f++) begin
            m = 2'($urandom_range(0, 2));
            send_frame(m, 6'($urandom), rand128(), rand256(), 2, 0, hw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
